// File: rtl/rocket_motion_ctrl_if.sv
`default_nettype none
// =============================================================================
// Module   : rocket_motion_ctrl_if
// Brief    : Key/tick inputs and position/strobe outputs of the rocket motion controller
// Revision : 1.0 - initial release
// =============================================================================
interface rocket_motion_ctrl_if;
  logic        frameTick;
  logic        keyUp;
  logic        keyDown;
  logic        keyLeft;
  logic        keyRight;
  logic        drawDone;
  logic [16:0] rocketLocation;
  logic [8:0]  rocketX;
  logic [7:0]  rocketY;
  logic        moveUp;
  logic        moveDown;
  logic        moveLeft;
  logic        moveRight;
  logic        drawStart;
  logic        busy;

  modport master (
    output frameTick, keyUp, keyDown, keyLeft, keyRight, drawDone,
    input  rocketLocation, rocketX, rocketY,
    input  moveUp, moveDown, moveLeft, moveRight, drawStart, busy
  );

  modport slave (
    input  frameTick, keyUp, keyDown, keyLeft, keyRight, drawDone,
    output rocketLocation, rocketX, rocketY,
    output moveUp, moveDown, moveLeft, moveRight, drawStart, busy
  );
endinterface
`default_nettype wire

// File: rtl/rocket_motion_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : rocket_motion_ctrl
// Brief    : Key/frame-tick driven rocket position with move strobes and redraw
//            handshake. Optional macro ROCKET_WRAP_EN makes horizontal moves wrap.
// Revision : 1.0 - initial release
// =============================================================================
module rocket_motion_ctrl #(
  parameter int SCREEN_W       = 320,
  parameter int SCREEN_H       = 240,
  parameter int MARGIN         = 16,
  parameter int START_X        = 160,
  parameter int START_Y        = 200,
  parameter int TICKS_PER_MOVE = 2
) (
  input  wire logic           clock,
  input  wire logic           resetn,
  rocket_motion_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    INIT      = 3'd0,
    IDLE      = 3'd1,
    EVAL      = 3'd2,
    STEP      = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

`ifdef ROCKET_WRAP_EN
  localparam bit c_wrapEn = 1'b1;
`else
  localparam bit c_wrapEn = 1'b0;
`endif

  localparam int          c_divW     = $clog2(TICKS_PER_MOVE + 1);
  localparam logic [c_divW-1:0] c_divLast = c_divW'(TICKS_PER_MOVE - 1);
  localparam logic [8:0]  c_xMin     = 9'(MARGIN);
  localparam logic [8:0]  c_xMax     = 9'(SCREEN_W - 1 - MARGIN);
  localparam logic [7:0]  c_yMin     = 8'(MARGIN);
  localparam logic [7:0]  c_yMax     = 8'(SCREEN_H - 1 - MARGIN);
  localparam logic [16:0] c_stride   = 17'(SCREEN_W);
  localparam logic [16:0] c_wrapSpan = 17'(SCREEN_W - 1 - 2 * MARGIN);
  localparam logic [16:0] c_startLoc = 17'(START_Y * SCREEN_W + START_X);

  state_t              r_state, w_stateNext;
  dir_t                r_dir, w_dirNext;
  logic [c_divW-1:0]   r_div, w_divNext;
  logic [8:0]          r_x, w_xNext;
  logic [7:0]          r_y, w_yNext;
  logic [16:0]         r_loc, w_locNext;
  logic [3:0]          r_moves, w_movesNext;   // {right, left, down, up}
  logic                r_drawStart, w_drawStartNext;
  logic                r_busy, w_busyNext;

  // Opposite keys cancel before priority is applied
  logic w_goUp, w_goDown, w_goLeft, w_goRight;
  assign w_goUp    = bus.keyUp    & ~bus.keyDown;
  assign w_goDown  = bus.keyDown  & ~bus.keyUp;
  assign w_goLeft  = bus.keyLeft  & ~bus.keyRight;
  assign w_goRight = bus.keyRight & ~bus.keyLeft;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state     <= INIT;
      r_dir       <= DIR_UP;
      r_div       <= '0;
      r_x         <= 9'(START_X);
      r_y         <= 8'(START_Y);
      r_loc       <= c_startLoc;
      r_moves     <= '0;
      r_drawStart <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_dir       <= w_dirNext;
      r_div       <= w_divNext;
      r_x         <= w_xNext;
      r_y         <= w_yNext;
      r_loc       <= w_locNext;
      r_moves     <= w_movesNext;
      r_drawStart <= w_drawStartNext;
      r_busy      <= w_busyNext;
    end
  end

  always_comb begin
    w_stateNext     = r_state;
    w_dirNext       = r_dir;
    w_divNext       = r_div;
    w_xNext         = r_x;
    w_yNext         = r_y;
    w_locNext       = r_loc;
    w_movesNext     = 4'b0000;
    w_drawStartNext = 1'b0;
    w_busyNext      = r_busy;
    case (r_state)
      INIT: begin
        w_drawStartNext = 1'b1;
        w_busyNext      = 1'b1;
        w_stateNext     = WAIT_DONE;
      end
      IDLE: begin
        if (bus.frameTick) begin
          if (r_div == c_divLast) begin
            w_divNext   = '0;
            w_stateNext = EVAL;
          end else begin
            w_divNext = r_div + 1'b1;
          end
        end
      end
      EVAL: begin
        // A blocked winner does not fall through to a lower-priority key
        w_stateNext = IDLE;
        if (w_goUp) begin
          if (r_y != c_yMin) begin w_dirNext = DIR_UP; w_stateNext = STEP; end
        end else if (w_goDown) begin
          if (r_y != c_yMax) begin w_dirNext = DIR_DOWN; w_stateNext = STEP; end
        end else if (w_goLeft) begin
          if (c_wrapEn || (r_x != c_xMin)) begin w_dirNext = DIR_LEFT; w_stateNext = STEP; end
        end else if (w_goRight) begin
          if (c_wrapEn || (r_x != c_xMax)) begin w_dirNext = DIR_RIGHT; w_stateNext = STEP; end
        end
      end
      STEP: begin
        w_drawStartNext = 1'b1;
        w_busyNext      = 1'b1;
        w_stateNext     = WAIT_DONE;
        case (r_dir)
          DIR_UP: begin
            w_yNext     = r_y - 1'b1;
            w_locNext   = r_loc - c_stride;
            w_movesNext = 4'b0001;
          end
          DIR_DOWN: begin
            w_yNext     = r_y + 1'b1;
            w_locNext   = r_loc + c_stride;
            w_movesNext = 4'b0010;
          end
          DIR_LEFT: begin
            if (c_wrapEn && (r_x == c_xMin)) begin
              w_xNext   = c_xMax;
              w_locNext = r_loc + c_wrapSpan;
            end else begin
              w_xNext   = r_x - 1'b1;
              w_locNext = r_loc - 17'd1;
            end
            w_movesNext = 4'b0100;
          end
          DIR_RIGHT: begin
            if (c_wrapEn && (r_x == c_xMax)) begin
              w_xNext   = c_xMin;
              w_locNext = r_loc - c_wrapSpan;
            end else begin
              w_xNext   = r_x + 1'b1;
              w_locNext = r_loc + 17'd1;
            end
            w_movesNext = 4'b1000;
          end
        endcase
      end
      WAIT_DONE: begin
        // The strobe cycle is the first WAIT_DONE cycle; a coincident drawDone is ignored
        if (bus.drawDone && !r_drawStart) begin
          w_busyNext  = 1'b0;
          w_stateNext = IDLE;
        end
      end
      default: w_stateNext = INIT;
    endcase
  end

  assign bus.rocketLocation = r_loc;
  assign bus.rocketX        = r_x;
  assign bus.rocketY        = r_y;
  assign bus.moveUp         = r_moves[0];
  assign bus.moveDown       = r_moves[1];
  assign bus.moveLeft       = r_moves[2];
  assign bus.moveRight      = r_moves[3];
  assign bus.drawStart      = r_drawStart;
  assign bus.busy           = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rocket_motion_ctrl.sv
`default_nettype none
// Testbench for rocket_motion_ctrl: random key patterns against a coordinate-level
// model of the clamp/wrap and priority rules.
module tb_rocket_motion_ctrl;
  localparam int W = 320, H = 240, M = 16, X0 = 160, Y0 = 200, TPM = 2;
  localparam int XMAX = W - 1 - M, YMAX = H - 1 - M;
`ifdef ROCKET_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clock = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   mx = X0;
  int   my = Y0;

  rocket_motion_ctrl_if bus();
  rocket_motion_ctrl dut (.clock(clock), .resetn(resetn), .bus(bus));

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [3:0] strobes();
    return {bus.moveRight, bus.moveLeft, bus.moveDown, bus.moveUp};
  endfunction

  // keys/result bit order: {right, left, down, up}
  function automatic logic [3:0] model_move(input logic [3:0] keys, input int x, input int y);
    bit up    = keys[0] && !keys[1];
    bit down  = keys[1] && !keys[0];
    bit left  = keys[2] && !keys[3];
    bit right = keys[3] && !keys[2];
    if (up)    return (y > M)             ? 4'b0001 : 4'b0000;
    if (down)  return (y < YMAX)          ? 4'b0010 : 4'b0000;
    if (left)  return (x > M || WRAP)     ? 4'b0100 : 4'b0000;
    if (right) return (x < XMAX || WRAP)  ? 4'b1000 : 4'b0000;
    return 4'b0000;
  endfunction

  task automatic apply_model(input logic [3:0] mv);
    case (mv)
      4'b0001: my = my - 1;
      4'b0010: my = my + 1;
      4'b0100: mx = (mx == M) ? XMAX : mx - 1;
      4'b1000: mx = (mx == XMAX) ? M : mx + 1;
      default: ;
    endcase
  endtask

  task automatic drive_keys(input logic [3:0] k);
    bus.keyUp = k[0]; bus.keyDown = k[1]; bus.keyLeft = k[2]; bus.keyRight = k[3];
  endtask

  task automatic pulse_ticks(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      bus.frameTick = 1'b1;
      step();
      bus.frameTick = 1'b0;
      if (gaps && i < n - 1) repeat ($urandom_range(0, 2)) step();
    end
  endtask

  task automatic run_update(input logic [3:0] keys, input string name);
    logic [3:0] exp;
    exp = model_move(keys, mx, my);
    apply_model(exp);
    drive_keys(keys);
    pulse_ticks(TPM, 1'b1);
    step();
    step();
    checks++; if (strobes() !== exp) begin failures++; $display("FAIL %s strobes got=%b exp=%b", name, strobes(), exp); end
    checks++; if (bus.drawStart !== (exp != 0)) begin failures++; $display("FAIL %s drawStart got=%b exp=%b", name, bus.drawStart, (exp != 0)); end
    checks++; if (bus.rocketX !== 9'(mx)) begin failures++; $display("FAIL %s rocketX got=%0d exp=%0d", name, bus.rocketX, mx); end
    checks++; if (bus.rocketY !== 8'(my)) begin failures++; $display("FAIL %s rocketY got=%0d exp=%0d", name, bus.rocketY, my); end
    checks++; if (bus.rocketLocation !== 17'(my * W + mx)) begin failures++; $display("FAIL %s location got=%0d exp=%0d", name, bus.rocketLocation, my * W + mx); end
    checks++; if (bus.busy !== (exp != 0)) begin failures++; $display("FAIL %s busy got=%b exp=%b", name, bus.busy, (exp != 0)); end
    step();
    checks++; if ({strobes(), bus.drawStart} !== 5'b0) begin failures++; $display("FAIL %s strobe_width got=%b exp=00000", name, {strobes(), bus.drawStart}); end
    if (exp != 0) begin
      bus.drawDone = 1'b1;
      step();
      bus.drawDone = 1'b0;
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL %s busy_after_done got=%b exp=0", name, bus.busy); end
    end
    drive_keys(4'b0000);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    step(); step();
    checks++; if (bus.rocketX !== 9'd160) begin failures++; $display("FAIL reset_x got=%0d exp=160", bus.rocketX); end
    checks++; if (bus.rocketY !== 8'd200) begin failures++; $display("FAIL reset_y got=%0d exp=200", bus.rocketY); end
    checks++; if (bus.rocketLocation !== 17'd64160) begin failures++; $display("FAIL reset_loc got=%0d exp=64160", bus.rocketLocation); end
    checks++; if ({strobes(), bus.drawStart, bus.busy} !== 6'b0) begin failures++; $display("FAIL reset_strobes got=%b exp=000000", {strobes(), bus.drawStart, bus.busy}); end
    resetn = 1'b1;
    step();
    checks++; if (bus.drawStart !== 1'b1 || strobes() !== 4'b0) begin failures++; $display("FAIL init_paint got=%b%b exp=10000", bus.drawStart, strobes()); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL init_busy got=%b exp=1", bus.busy); end
    bus.drawDone = 1'b1;   // coincident with the strobe: must be ignored
    step();
    bus.drawDone = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.drawStart !== 1'b0) begin failures++; $display("FAIL init_coincident_done got=%b%b exp=10", bus.busy, bus.drawStart); end
    bus.drawDone = 1'b1;
    step();
    bus.drawDone = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL init_done got=%b exp=0", bus.busy); end
    mx = X0; my = Y0;
  endtask

  task automatic test_right();
    run_update(4'b1000, "right_first");
    checks++; if (bus.rocketLocation !== 17'd64161) begin failures++; $display("FAIL right_loc got=%0d exp=64161", bus.rocketLocation); end
  endtask

  task automatic test_priority();
    run_update(4'b0101, "up_over_left");
    run_update(4'b0011, "up_down_cancel");
    run_update(4'b0111, "updown_cancel_left");
    run_update(4'b1110, "leftright_cancel_down");
    run_update(4'b1100, "leftright_cancel");
  endtask

  task automatic test_drop_ticks();
    logic [3:0] exp;
    exp = model_move(4'b1000, mx, my);
    apply_model(exp);
    drive_keys(4'b1000);
    pulse_ticks(TPM, 1'b0);
    step(); step();
    checks++; if (strobes() !== exp) begin failures++; $display("FAIL drop_first got=%b exp=%b", strobes(), exp); end
    bus.frameTick = 1'b1;
    repeat (3) step();
    bus.frameTick = 1'b0;
    bus.drawDone = 1'b1;
    step();
    bus.drawDone = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL drop_done got=%b exp=0", bus.busy); end
    pulse_ticks(TPM - 1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++; if ({strobes(), bus.drawStart} !== 5'b0) begin failures++; $display("FAIL drop_no_strobe got=%b exp=00000", {strobes(), bus.drawStart}); end
      step();
    end
    exp = model_move(4'b1000, mx, my);
    apply_model(exp);
    pulse_ticks(1, 1'b0);
    step(); step();
    checks++; if (strobes() !== exp || bus.rocketX !== 9'(mx)) begin failures++; $display("FAIL drop_resume got=%b/%0d exp=%b/%0d", strobes(), bus.rocketX, exp, mx); end
    step();
    bus.drawDone = 1'b1;
    step();
    bus.drawDone = 1'b0;
    drive_keys(4'b0000);
  endtask

  task automatic test_edges();
    while (my < YMAX) run_update(4'b0010, "down_walk");
    run_update(4'b0010, "down_clamp");
    run_update(4'b0110, "down_blocked_no_fallback");
    while (mx > M) run_update(4'b0100, "left_walk");
    run_update(4'b0100, "left_edge");
    while (mx < XMAX) run_update(4'b1000, "right_walk");
    run_update(4'b1000, "right_edge");
    while (my > M) run_update(4'b0001, "up_walk");
    run_update(4'b0001, "up_clamp");
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) run_update(4'($urandom_range(0, 15)), "random");
  endtask

  task automatic test_reset_in_wait();
    drive_keys(4'b0010);
    pulse_ticks(TPM, 1'b0);
    step(); step();
    resetn = 1'b0;
    step();
    mx = X0; my = Y0;
    checks++; if (bus.rocketX !== 9'(X0) || bus.rocketY !== 8'(Y0)) begin failures++; $display("FAIL rst_wait_xy got=%0d,%0d exp=%0d,%0d", bus.rocketX, bus.rocketY, X0, Y0); end
    checks++; if (bus.rocketLocation !== 17'd64160) begin failures++; $display("FAIL rst_wait_loc got=%0d exp=64160", bus.rocketLocation); end
    checks++; if ({strobes(), bus.drawStart, bus.busy} !== 6'b0) begin failures++; $display("FAIL rst_wait_flags got=%b exp=000000", {strobes(), bus.drawStart, bus.busy}); end
    resetn = 1'b1;
    drive_keys(4'b0000);
    step();
    checks++; if (bus.drawStart !== 1'b1 || strobes() !== 4'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL rst_wait_init got=%b%b%b exp=110000", bus.drawStart, bus.busy, strobes()); end
    step();
    bus.drawDone = 1'b1;
    step();
    bus.drawDone = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_wait_done got=%b exp=0", bus.busy); end
    run_update(4'b0100, "after_reset_left");
  endtask

  initial begin
    bus.frameTick = 1'b0;
    bus.drawDone  = 1'b0;
    drive_keys(4'b0000);
    test_reset();
    test_right();
    test_priority();
    test_drop_ticks();
    test_edges();
    test_random();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/rocket_motion_ctrl.md
# rocket_motion_ctrl

Upstream stage of the rocket sprite renderer. It converts debounced direction keys and a per-frame tick into a rocket position: a linear framebuffer address `rocketLocation = y*320 + x` plus X/Y coordinates. Once per update it issues a one-cycle move strobe to the renderer, then holds off further updates until the renderer reports that the redraw is finished. Position is clamped to keep the ±15-pixel sprite fully on the 320×240 screen.

## Interface
- `SCREEN_W`, 320, screen width in pixels; also the row stride of `rocketLocation`
- `SCREEN_H`, 240, screen height in pixels
- `MARGIN`, 16, minimum distance from the rocket centre to any screen edge
- `START_X`, 160, X coordinate after reset
- `START_Y`, 200, Y coordinate after reset
- `TICKS_PER_MOVE`, 2, number of `frameTick` pulses per position update (≥1)

- `clock` in 1 — single system clock
- `resetn` in 1 — one clock; reset is synchronous and active-low
- `frameTick` in 1 — one-cycle pulse, once per video frame
- `keyUp`, `keyDown`, `keyLeft`, `keyRight` in 1 each — level-sensitive, already debounced
- `drawDone` in 1 — one-cycle pulse from the renderer when a redraw completes
- `rocketLocation` out 17 — `rocketY*SCREEN_W + rocketX`
- `rocketX` out 9 — centre X
- `rocketY` out 8 — centre Y
- `moveUp`, `moveDown`, `moveLeft`, `moveRight` out 1 each — one-cycle strobes, at most one high at a time
- `drawStart` out 1 — one-cycle strobe; the OR of the move strobes, and also asserted alone for the initial paint
- `busy` out 1 — high from the strobe cycle until `drawDone` is accepted

## Operation
- Reset values:
  - `rocketX = START_X`, `rocketY = START_Y`
  - `rocketLocation = 64160` with default parameters
  - all strobes 0, `busy = 0`
  - divider count 0, state INIT
- FSM states: INIT, IDLE, EVAL, STEP, WAIT_DONE.
  - **INIT**: pulse `drawStart` with no move bit (full sprite paint), set `busy`, go to WAIT_DONE.
  - **IDLE**: on `frameTick`, increment the divider. When the divider reaches `TICKS_PER_MOVE`, clear it and go to EVAL.
  - **EVAL**: sample the keys.
    - Opposite pairs cancel: up+down means no vertical move; left+right means no horizontal move.
    - Of the remaining keys, the priority is Up > Down > Left > Right.
    - If no direction remains, or the chosen move is blocked by the boundary, return to IDLE with no strobe.
  - **STEP**: update the position by one pixel and pulse the selected move strobe plus `drawStart`. Set `busy` and go to WAIT_DONE.
    - Up: `y-1`, location −`SCREEN_W`
    - Down: `y+1`, location +`SCREEN_W`
    - Left: `x-1`, location −1
    - Right: `x+1`, location +1
  - **WAIT_DONE**: on `drawDone`, clear `busy` and go to IDLE.
- Arithmetic and range rules:
  - `rocketLocation` is maintained incrementally (add/subtract only, no multiplier) and must always equal `y*SCREEN_W + x`.
  - Valid X range is `[MARGIN, SCREEN_W-1-MARGIN]`, i.e. [16, 303]. Valid Y range is `[MARGIN, SCREEN_H-1-MARGIN]`, i.e. [16, 223].
  - A move that would leave the valid range is blocked (clamp).
- Boundary conditions:
  - `frameTick` pulses in any state other than IDLE are dropped, not queued; the divider does not advance.
  - `drawDone` outside WAIT_DONE is ignored.
  - `resetn` low in any state, including WAIT_DONE, restores all reset values on the next edge. The module then repaints from INIT.

## Timing
- INIT strobe appears in the first cycle after reset deasserts.
- `frameTick` completing the divider is registered at edge k; EVAL is at edge k+1.
- STEP outputs are registered: the new `rocketX`, `rocketY` and `rocketLocation`, the move strobe and `drawStart` are all visible after edge k+2 and are valid together in that cycle.
- Each strobe is exactly one cycle wide. `busy` rises with the strobe.
- WAIT_DONE is entered the cycle after the strobe, so a `drawDone` coincident with the strobe is ignored.
- `busy` falls one cycle after an accepted `drawDone`. The earliest next update requires a fresh `frameTick` after that point.

## Configuration
- **`ROCKET_WRAP_EN`**:
  - Defined: horizontal moves wrap instead of clamping.
    - Left at x=16 goes to x=303, location +287.
    - Right at x=303 goes to x=16, location −287.
    - The corresponding strobe is still issued.
  - Not defined: horizontal moves clamp as described above.
  - Vertical moves clamp in both builds.

## Test plan
- Reset released -> `drawStart` pulses alone in cycle 1 with `rocketLocation = 64160` and `busy = 1`; `drawDone` -> `busy = 0`.
- `keyRight` held, two `frameTick`s -> `moveRight` pulse two cycles after the second tick, `rocketX = 161`, `rocketLocation = 64161`; no further update until `drawDone`.
- `keyUp` and `keyLeft` held -> only `moveUp` strobes, `rocketY = 199`, location −320; up+down with no other key -> no strobe.
- `keyDown` held from y=223 -> no strobe, position unchanged, FSM back in IDLE; `keyLeft` at x=16 -> blocked (default build), wraps to x=303 / location +287 with `ROCKET_WRAP_EN`.
- `frameTick` pulses during WAIT_DONE -> divider unchanged and no strobe after `drawDone`.
- `resetn` asserted during WAIT_DONE -> next cycle shows reset values, followed by an INIT `drawStart`.
